// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: UART command decoder for RF access and gated ALU ops, serialising results to TX.
// Define SYS_CMD_CHKSUM_EN to append an XOR checksum byte to every read/ALU response.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int ALU_OUT_BYTES  = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [DATA_WIDTH-1:0]               RX_DATA,
    input  logic                                RX_VALID,
    input  logic                                TX_BUSY,
    input  logic [DATA_WIDTH-1:0]               RF_RD_DATA,
    input  logic                                RF_RD_VALID,
    input  logic [ALU_OUT_BYTES*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                                ALU_VALID,
    output logic                                RF_WR_EN,
    output logic                                RF_RD_EN,
    output logic [ADDR_WIDTH-1:0]               RF_ADDR,
    output logic [DATA_WIDTH-1:0]               RF_WR_DATA,
    output logic                                ALU_EN,
    output logic [FUN_WIDTH-1:0]                ALU_FUN,
    output logic                                CLK_GATE_EN,
    output logic                                CLK_DIV_EN,
    output logic [DATA_WIDTH-1:0]               TX_DATA,
    output logic                                TX_VALID,
    output logic                                ERR
);

`ifdef SYS_CMD_CHKSUM_EN
    localparam int NB   = ALU_OUT_BYTES + 1;
    localparam int RD_N = 2;
`else
    localparam int NB   = ALU_OUT_BYTES;
    localparam int RD_N = 1;
`endif
    localparam int RW = NB * DATA_WIDTH;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN,
        ALU_GATE, ALU_WAIT, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
    } state_t;

    state_t          state, prev_state;
    logic [TW-1:0]   tmo;
    logic [RW-1:0]   res, res_rd, res_alu;
    logic [CW-1:0]   cnt;
    logic [7:0]      cmd;
    logic            tmo_hit, timed, busy_state;

    assign cmd        = RX_DATA[7:0];
    assign tmo_hit    = tmo == TW'(TIMEOUT_CYCLES) && state == prev_state;
    assign timed      = state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN, TX_WAIT_HI};
    assign busy_state = state inside {RD_WAIT, ALU_GATE, ALU_WAIT, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO};

`ifdef SYS_CMD_CHKSUM_EN
    logic [DATA_WIDTH-1:0] alu_x;
    always_comb begin
        alu_x = '0;
        for (int i = 0; i < ALU_OUT_BYTES; i++) alu_x = alu_x ^ ALU_OUT[i*DATA_WIDTH +: DATA_WIDTH];
    end
    assign res_rd  = RW'({RF_RD_DATA, RF_RD_DATA});
    assign res_alu = {alu_x, ALU_OUT};
`else
    assign res_rd  = RW'(RF_RD_DATA);
    assign res_alu = ALU_OUT;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            prev_state  <= IDLE;
            tmo         <= '0;
            res         <= '0;
            cnt         <= '0;
            RF_WR_EN    <= 1'b0;
            RF_RD_EN    <= 1'b0;
            RF_ADDR     <= '0;
            RF_WR_DATA  <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            CLK_DIV_EN  <= 1'b0;
            TX_DATA     <= '0;
            TX_VALID    <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            prev_state <= state;
            tmo        <= (RX_VALID || state != prev_state) ? '0 :
                          (tmo == TW'(TIMEOUT_CYCLES) ? tmo : tmo + 1'b1);
            CLK_DIV_EN <= 1'b1;
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            ALU_EN     <= 1'b0;
            TX_VALID   <= 1'b0;
            ERR        <= RX_VALID && busy_state;
            if (timed && !RX_VALID && tmo_hit) begin
                ERR         <= 1'b1;
                CLK_GATE_EN <= 1'b0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: if (RX_VALID) begin
                        state <= cmd == 8'hAA ? WR_ADDR : cmd == 8'hBB ? RD_ADDR :
                                 cmd == 8'hCC ? OP_A : cmd == 8'hDD ? OP_FUN : IDLE;
                        ERR   <= !(cmd inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    end
                    WR_ADDR: if (RX_VALID) begin
                        RF_ADDR <= RX_DATA[ADDR_WIDTH-1:0];
                        state   <= WR_DATA;
                    end
                    WR_DATA: if (RX_VALID) begin
                        RF_WR_DATA <= RX_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= IDLE;
                    end
                    RD_ADDR: if (RX_VALID) begin
                        RF_ADDR  <= RX_DATA[ADDR_WIDTH-1:0];
                        RF_RD_EN <= 1'b1;
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: if (RF_RD_VALID) begin
                        res   <= res_rd;
                        cnt   <= CW'(RD_N);
                        state <= TX_LOAD;
                    end
                    OP_A: if (RX_VALID) begin
                        RF_ADDR    <= '0;
                        RF_WR_DATA <= RX_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= OP_B;
                    end
                    OP_B: if (RX_VALID) begin
                        RF_ADDR    <= ADDR_WIDTH'(1);
                        RF_WR_DATA <= RX_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= OP_FUN;
                    end
                    OP_FUN: if (RX_VALID) begin
                        ALU_FUN     <= RX_DATA[FUN_WIDTH-1:0];
                        CLK_GATE_EN <= 1'b1;
                        state       <= ALU_GATE;
                    end
                    ALU_GATE: begin
                        ALU_EN <= 1'b1;
                        state  <= ALU_WAIT;
                    end
                    ALU_WAIT: if (ALU_VALID) begin
                        CLK_GATE_EN <= 1'b0;
                        res         <= res_alu;
                        cnt         <= CW'(NB);
                        state       <= TX_LOAD;
                    end
                    TX_LOAD: if (!TX_BUSY) begin
                        TX_VALID <= 1'b1;
                        TX_DATA  <= res[DATA_WIDTH-1:0];
                        res      <= res >> DATA_WIDTH;
                        cnt      <= cnt - 1'b1;
                        state    <= TX_WAIT_HI;
                    end
                    TX_WAIT_HI: if (TX_BUSY) state <= TX_WAIT_LO;
                    TX_WAIT_LO: if (!TX_BUSY) state <= cnt == '0 ? IDLE : TX_LOAD;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Parametrised successor to the fixed 8-bit UART command controller. It runs in the REF_CLK domain.
- Decodes synchronised UART RX byte frames into register-file reads/writes and ALU operations.
- Gates the ALU clock and serialises multi-byte results back to the UART TX path, handshaking on the synchronised TX busy.
- Adds a per-byte inter-frame timeout and an error flag.

Parameters:
DATA_WIDTH, 8, width of UART bytes, RF data and ALU operands
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
ALU_OUT_BYTES, 2, result bytes sent per ALU op (ALU_OUT width = ALU_OUT_BYTES*DATA_WIDTH)
TIMEOUT_CYCLES, 1023, max CLK cycles waited for next RX byte or a TX_BUSY edge

Ports:
CLK  in  1  REF_CLK-domain clock
RST  in  1  asynchronous, active-high reset
RX_DATA  in  DATA_WIDTH  synchronised RX byte
RX_VALID  in  1  one-cycle pulse, RX_DATA valid
TX_BUSY  in  1  synchronised UART TX busy
RF_RD_DATA  in  DATA_WIDTH  register-file read data
RF_RD_VALID  in  1  read data valid pulse
ALU_OUT  in  ALU_OUT_BYTES*DATA_WIDTH  ALU result
ALU_VALID  in  1  ALU result valid pulse
RF_WR_EN  out  1  write strobe
RF_RD_EN  out  1  read strobe
RF_ADDR  out  ADDR_WIDTH  register-file address
RF_WR_DATA  out  DATA_WIDTH  write data
ALU_EN  out  1  ALU start pulse
ALU_FUN  out  FUN_WIDTH  ALU function
CLK_GATE_EN  out  1  ALU clock-gate enable
CLK_DIV_EN  out  1  TX clock-divider enable
TX_DATA  out  DATA_WIDTH  byte to UART TX
TX_VALID  out  1  one-cycle TX request
ERR  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0, FSM = IDLE, timeout counter 0. CLK_DIV_EN goes to 1 on the first clock after reset release and stays 1.
- All outputs are registered. Strobes (RF_WR_EN, RF_RD_EN, ALU_EN, TX_VALID, ERR) are exactly one cycle wide.
- Commands (first byte, low 8 bits compared):
  - 0xAA write: ADDR, DATA.
  - 0xBB read: ADDR.
  - 0xCC ALU with operands: A, B, FUN.
  - 0xDD ALU no-operand: FUN.
- Unknown first byte: ERR pulse, stay IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, ALU_GATE, ALU_WAIT, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
- Address and function bytes are truncated to their low ADDR_WIDTH / FUN_WIDTH bits.
- Write (0xAA): the cycle after the DATA byte's RX_VALID, RF_WR_EN=1 with RF_ADDR/RF_WR_DATA; then IDLE.
- Read (0xBB): the cycle after ADDR, RF_RD_EN=1, then RD_WAIT. On RF_RD_VALID, capture RF_RD_DATA into result byte 0 (count=1), then TX_LOAD.
- Operands (0xCC):
  - A is written to RF address 0 and B to RF address 1, each with an RF_WR_EN pulse the cycle after its byte arrives.
  - After FUN, go to OP_FUN exit.
- ALU start (both 0xCC and 0xDD):
  - ALU_GATE: CLK_GATE_EN=1 for one cycle.
  - Next cycle: ALU_EN=1, ALU_FUN is held.
  - ALU_WAIT: CLK_GATE_EN stays 1 until the cycle ALU_VALID is seen, then drops to 0.
  - Capture ALU_OUT into the result buffer (count=ALU_OUT_BYTES), then TX_LOAD.
- TX serialisation, LSB byte first:
  - TX_LOAD issues TX_VALID with TX_DATA only when TX_BUSY=0.
  - TX_WAIT_HI waits for TX_BUSY=1; TX_WAIT_LO waits for TX_BUSY=0.
  - Then next byte, or IDLE when count is exhausted.
- Timeout:
  - A counter resets on every RX_VALID or state change.
  - In any mid-frame RX state or TX_WAIT_HI, reaching TIMEOUT_CYCLES gives ERR, abort to IDLE, CLK_GATE_EN=0, partial frame discarded.
  - RD_WAIT and ALU_WAIT have no timeout.
- RX_VALID in RD_WAIT, ALU_GATE, ALU_WAIT or any TX state: byte dropped, ERR pulse, FSM unaffected.
- RST asserted mid-operation: immediate return to reset values. No partial TX byte is issued afterwards.

Optional Feature:
- Macro: SYS_CMD_CHKSUM_EN.
- Defined: after the last result byte of every read or ALU response, one extra byte is sent, equal to the XOR of all response bytes, using the same TX handshake. Read responses become 2 bytes and ALU responses ALU_OUT_BYTES+1 bytes.
- Undefined: no checksum byte, no XOR logic.

Test Plan:
- RX 0xAA,0x05,0x3C -> single RF_WR_EN with RF_ADDR=5, RF_WR_DATA=0x3C, one cycle after the third RX_VALID; no TX.
- RX 0xBB,0x02; RF returns 0x7E -> RF_RD_EN once with RF_ADDR=2; one TX_VALID with TX_DATA=0x7E after TX_BUSY=0; with SYS_CMD_CHKSUM_EN, a second byte 0x7E.
- RX 0xCC,0x10,0x20,0x0; ALU_OUT=0x0030 -> writes addr0=0x10 and addr1=0x20; CLK_GATE_EN rises one cycle before ALU_EN; TX bytes 0x30 then 0x00, the second only after a TX_BUSY high->low cycle.
- RX 0xDD,0x2 with TX_BUSY held 1 for 50 cycles -> TX_VALID withheld until TX_BUSY=0; no ERR.
- RX 0xAA,0x05, then silence for TIMEOUT_CYCLES -> ERR pulse, no RF_WR_EN; a following 0xAA,0x01,0x11 executes normally.
- RX 0x55 -> ERR pulse, IDLE. RX byte during ALU_WAIT -> ERR, result still sent. RST during TX_WAIT_LO -> all outputs 0, no further TX_VALID.
